// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the mux and demux stages.
// Slot numbering, sync-tracker states and default sample width.
package tdm_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    EXP_B = 2'd1,
    EXP_A = 2'd2
  } state_t;

  localparam logic SLOT_A = 1'b0;
  localparam logic SLOT_B = 1'b1;

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/tdm_sync_fsm.sv
// Tracks A/B slot alternation on the interleaved stream.
// Emits capture strobes and alignment errors per valid event.
module tdm_sync_fsm
  import tdm_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  logic   in_sync,
  output logic   cap_a,
  output logic   cap_b,
  output logic   err,
  output state_t state
);

  state_t nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= nxt;
  end

  always_comb begin
    nxt   = state;
    cap_a = 1'b0;
    cap_b = 1'b0;
    err   = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_sync) begin
            cap_a = 1'b1;
            nxt   = EXP_B;
          end
        end
        EXP_B: begin
          // a repeated sync restarts the frame on the new A
          if (!in_sync) begin
            cap_b = 1'b1;
            nxt   = EXP_A;
          end else begin
            cap_a = 1'b1;
            err   = 1'b1;
          end
        end
        EXP_A: begin
          if (in_sync) begin
            cap_a = 1'b1;
            nxt   = EXP_B;
          end else begin
            err = 1'b1;
            nxt = HUNT;
          end
        end
        default: nxt = HUNT;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: splits an interleaved stream
// into registered A/B samples with valid, pair and error strobes.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sync,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  output logic              pair_valid,
  output logic              locked,
  output logic              sync_err,
  output logic [ERR_W-1:0]  err_count
);

  logic   cap_a;
  logic   cap_b;
  logic   err;
  state_t st;

  tdm_sync_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .cap_a    (cap_a),
    .cap_b    (cap_b),
    .err      (err),
    .state    (st)
  );

  assign locked = (st != HUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_data     <= '0;
      b_data     <= '0;
      a_valid    <= 1'b0;
      b_valid    <= 1'b0;
      pair_valid <= 1'b0;
      sync_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      a_valid    <= cap_a;
      b_valid    <= cap_b;
      pair_valid <= cap_b;
      sync_err   <= err;
      if (cap_a) a_data <= in_data;
      if (cap_b) b_data <= in_data;
      // saturate rather than wrap
      if (err && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

endmodule
